reaction_timer_multi: RTL and testbench

Parametrised reaction-timer core for N players sharing one start and one clear input, with a per-player stop input. After start it waits a pseudo-random delay, lights the LED, and timestamps each player's stop press in milliseconds. It also detects false starts, applies a timeout, and reports the winner. It sits between the db_fsm debouncers and the bin2bcd/display path, and replaces the single-player controller plus the external LFSR.

---
 rtl/reaction_pkg.sv | 21 ++
 rtl/ms_tick_gen.sv | 25 ++
 rtl/reaction_timer_multi.sv | 164 ++++++++++++++++
 tb/tb_reaction_timer_multi.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared definitions for the multi-player reaction timer: state codes,
// LFSR constants and the winner-index width helper.
package reaction_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_ARMED = 3'd2,
      S_DONE  = 3'd3,
      S_FALSE = 3'd4
   } state_t;

   // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

   function automatic int win_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICKS_PER_MS-1, tick is high in the last count.
// clr restarts the count so the first tick lands TICKS_PER_MS cycles later.
module ms_tick_gen #(
   parameter int TICKS_PER_MS = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (TICKS_PER_MS <= 1) ? 1 : $clog2(TICKS_PER_MS);
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_MS - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        cnt <= '0;
      else if (clr || tick) cnt <= '0;
      else                 cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/reaction_timer_multi.sv
// N-player reaction timer: random delay, LED, per-player ms timestamps,
// false-start detection, timeout and winner selection.
module reaction_timer_multi #(
   parameter int          N_PLAYERS    = 2,
   parameter int          TIME_W       = 14,
   parameter int          TICKS_PER_MS = 50000,
   parameter int          MIN_DELAY_MS = 2000,
   parameter int          RAND_W       = 12,
   parameter int          MAX_TIME_MS  = 9999,
   parameter logic [15:0] LFSR_SEED    = reaction_pkg::LFSR_SEED_DEF
) (
   input  logic                                            clk,
   input  logic                                            reset_n,
   input  logic                                            start,
   input  logic                                            clear,
   input  logic [N_PLAYERS-1:0]                            stop,
   output logic                                            led,
   output logic [2:0]                                      state,
   output logic [N_PLAYERS*TIME_W-1:0]                     player_time,
   output logic [N_PLAYERS-1:0]                            player_valid,
   output logic [N_PLAYERS-1:0]                            timeout,
   output logic [N_PLAYERS-1:0]                            false_start,
   output logic [reaction_pkg::win_w(N_PLAYERS)-1:0]       winner,
   output logic                                            winner_valid,
   output logic                                            done_tick
);

   import reaction_pkg::*;

   localparam int                WIN_W  = win_w(N_PLAYERS);
   localparam int                DLY_W  = $clog2(MIN_DELAY_MS + 2**RAND_W);
   localparam logic [TIME_W-1:0] T_MAX  = TIME_W'(MAX_TIME_MS);
   localparam logic [TIME_W-1:0] T_LAST = TIME_W'(MAX_TIME_MS - 1);

   state_t                             state_q, state_d;
   logic [15:0]                        lfsr;
   logic                               ms_tick;
   logic [DLY_W-1:0]                   dly_q, dly_d;
   logic [TIME_W-1:0]                  tcnt_q, tcnt_d;
   logic [N_PLAYERS-1:0][TIME_W-1:0]   pt_q, pt_d;
   logic [N_PLAYERS-1:0]               pv_q, pv_d, to_q, to_d, fs_q, fs_d;
   logic [N_PLAYERS-1:0]               latch;
   logic [WIN_W-1:0]                   win_q, win_d;
   logic                               wv_q, wv_d, done_q;

   // Prescaler restarts on every state change so ms boundaries align to entry.
   ms_tick_gen #(.TICKS_PER_MS(TICKS_PER_MS)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (state_d != state_q),
      .tick    (ms_tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lfsr <= LFSR_SEED;
      else          lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      tcnt_d  = tcnt_q;
      pt_d    = pt_q;
      pv_d    = pv_q;
      to_d    = to_q;
      fs_d    = fs_q;
      win_d   = win_q;
      wv_d    = wv_q;
      latch   = '0;
      if (clear) begin
         state_d = S_IDLE;
         pt_d = '0; pv_d = '0; to_d = '0; fs_d = '0; win_d = '0; wv_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               dly_d   = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr[RAND_W-1:0]);
               pt_d = '0; pv_d = '0; to_d = '0; fs_d = '0; win_d = '0; wv_d = 1'b0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (|stop) begin
                  fs_d    = stop;
                  state_d = S_FALSE;
               end else if (ms_tick) begin
                  if (dly_q <= DLY_W'(1)) begin
                     tcnt_d  = '0;
                     state_d = S_ARMED;
                  end else begin
                     dly_d = dly_q - DLY_W'(1);
                  end
               end
            end
            S_ARMED: begin
               latch = stop & ~pv_q;
               for (int i = 0; i < N_PLAYERS; i++)
                  if (latch[i]) begin
                     pt_d[i] = tcnt_q;
                     pv_d[i] = 1'b1;
                  end
               // Scan high-to-low so the lowest simultaneous index wins.
               if (!wv_q && |latch) begin
                  wv_d = 1'b1;
                  for (int i = N_PLAYERS - 1; i >= 0; i--)
                     if (latch[i]) win_d = WIN_W'(i);
               end
               if (ms_tick && tcnt_q != T_MAX) tcnt_d = tcnt_q + TIME_W'(1);
               if (ms_tick && tcnt_q == T_LAST) begin
                  for (int i = 0; i < N_PLAYERS; i++)
                     if (!pv_d[i]) begin
                        pt_d[i] = T_MAX;
                        to_d[i] = 1'b1;
                        pv_d[i] = 1'b1;
                     end
                  state_d = S_DONE;
               end else if (&pv_d) begin
                  state_d = S_DONE;
               end
            end
            S_DONE, S_FALSE: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dly_q  <= '0;
         tcnt_q <= '0;
         pt_q   <= '0;
         pv_q   <= '0;
         to_q   <= '0;
         fs_q   <= '0;
         win_q  <= '0;
         wv_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         dly_q  <= dly_d;
         tcnt_q <= tcnt_d;
         pt_q   <= pt_d;
         pv_q   <= pv_d;
         to_q   <= to_d;
         fs_q   <= fs_d;
         win_q  <= win_d;
         wv_q   <= wv_d;
         done_q <= (state_d != state_q) && (state_d == S_DONE || state_d == S_FALSE);
      end
   end

   assign led          = (state_q == S_ARMED);
   assign state        = state_q;
   assign player_time  = pt_q;
   assign player_valid = pv_q;
   assign timeout      = to_q;
   assign false_start  = fs_q;
   assign winner       = win_q;
   assign winner_valid = wv_q;
   assign done_tick    = done_q;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Bench for reaction_timer_multi: directed rounds plus random rounds, all outputs
// compared every cycle against an offset/arithmetic model of the timer rules.
module tb_reaction_timer_multi;

   localparam int N = 3, TW = 14, TPM = 4, MIND = 3, RW = 2, MAXT = 20;

   logic            clk = 1'b0, reset_n = 1'b1, start = 1'b0, clear = 1'b0;
   logic [N-1:0]    stop = '0;
   logic            led, winner_valid, done_tick;
   logic [2:0]      state;
   logic [N*TW-1:0] player_time;
   logic [N-1:0]    player_valid, timeout, false_start;
   logic [1:0]      winner;

   reaction_timer_multi #(
      .N_PLAYERS(N), .TIME_W(TW), .TICKS_PER_MS(TPM), .MIN_DELAY_MS(MIND),
      .RAND_W(RW), .MAX_TIME_MS(MAXT), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .clear(clear), .stop(stop),
      .led(led), .state(state), .player_time(player_time), .player_valid(player_valid),
      .timeout(timeout), .false_start(false_start), .winner(winner),
      .winner_valid(winner_valid), .done_tick(done_tick)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int led_cnt = 0, done_cnt = 0;
   int cur = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   int           m_state, m_cyc, m_d, m_win;
   int           m_time [N];
   logic [15:0]  m_lfsr;
   logic [N-1:0] m_v, m_to, m_fs;
   logic         m_wv, m_done;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic logic [N*TW-1:0] pack_times();
      logic [N*TW-1:0] p;
      for (int i = 0; i < N; i++) p[i*TW +: TW] = TW'(m_time[i]);
      return p;
   endfunction

   // m_cyc is the offset of the current cycle within its state; ms ticks end
   // offsets TPM-1, 2*TPM-1, ... so the elapsed ms count is offset/TPM.
   always @(posedge clk or negedge reset_n) begin : model
      int ns, o, tc, t_win;
      int t_time [N];
      logic [N-1:0] t_v, t_to, t_fs, lat;
      logic t_wv, zap;
      if (!reset_n) begin
         m_state <= 0; m_cyc <= 0; m_d <= 0; m_lfsr <= 16'hACE1; m_done <= 1'b0;
         for (int i = 0; i < N; i++) m_time[i] <= 0;
         m_v <= '0; m_to <= '0; m_fs <= '0; m_win <= 0; m_wv <= 1'b0;
      end else begin
         ns = m_state; o = m_cyc; zap = 1'b0;
         t_time = m_time; t_v = m_v; t_to = m_to; t_fs = m_fs; t_win = m_win; t_wv = m_wv;
         if (clear) begin
            ns = 0; zap = 1'b1;
         end else if (m_state == 0 && start) begin
            m_d <= MIND + int'(m_lfsr[RW-1:0]);
            zap = 1'b1; ns = 1;
         end else if (m_state == 1) begin
            if (stop != 0) begin t_fs = stop; ns = 4; end
            else if (o + 1 == m_d * TPM) ns = 2;
         end else if (m_state == 2) begin
            tc  = (o / TPM > MAXT) ? MAXT : o / TPM;
            lat = stop & ~t_v;
            for (int i = 0; i < N; i++) if (lat[i]) begin t_time[i] = tc; t_v[i] = 1'b1; end
            if (!t_wv && lat != 0) begin
               t_wv = 1'b1;
               for (int i = N - 1; i >= 0; i--) if (lat[i]) t_win = i;
            end
            if (o + 1 == MAXT * TPM) begin
               for (int i = 0; i < N; i++)
                  if (!t_v[i]) begin t_time[i] = MAXT; t_to[i] = 1'b1; t_v[i] = 1'b1; end
               ns = 3;
            end else if (&t_v) ns = 3;
         end
         if (zap) begin
            for (int i = 0; i < N; i++) t_time[i] = 0;
            t_v = '0; t_to = '0; t_fs = '0; t_win = 0; t_wv = 1'b0;
         end
         m_done  <= (ns != m_state) && (ns == 3 || ns == 4);
         m_cyc   <= (ns != m_state) ? 0 : m_cyc + 1;
         m_state <= ns;
         m_lfsr  <= lfsr_step(m_lfsr);
         m_time  <= t_time; m_v <= t_v; m_to <= t_to; m_fs <= t_fs; m_win <= t_win; m_wv <= t_wv;
      end
   end

   always @(negedge clk) begin
      chk("state", state, m_state);
      chk("led", led, m_state == 2);
      chk("player_time", player_time, pack_times());
      chk("player_valid", player_valid, m_v);
      chk("timeout", timeout, m_to);
      chk("false_start", false_start, m_fs);
      chk("winner_valid", winner_valid, m_wv);
      chk("winner", winner, m_win);
      chk("done_tick", done_tick, m_done);
      led_cnt  <= led_cnt + (led ? 1 : 0);
      done_cnt <= done_cnt + (done_tick ? 1 : 0);
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1; tick(); clear = 1'b0;
   endtask

   task automatic pulse_stop(input logic [N-1:0] m);
      stop = m; tick(); stop = '0; cur++;
   endtask

   task automatic goto(input int o);
      tick(o - cur); cur = o;
   endtask

   task automatic wait_led(output int n);
      n = 0;
      while (!led && n < 60) begin tick(); n++; end
      chk("wait_led", led, 1'b1);
      cur = 0;
   endtask

   task automatic wait_state(input int s, output int n);
      n = 0;
      while (state != 3'(s) && n < 200) begin tick(); n++; end
      chk("wait_state", state, s);
   endtask

   function automatic logic [TW-1:0] ptime(input int i);
      return player_time[i*TW +: TW];
   endfunction

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : driver
      int n, d0, l0;
      #1 reset_n = 1'b0;
      tick(2);
      #2;
      chk("rst_state", state, 0);
      chk("rst_led", led, 0);
      chk("rst_valid", player_valid, 0);
      tick();
      // start on the first post-reset edge: lfsr=ACE1, low bits 01 -> 4 ms
      reset_n = 1'b1;
      pulse_start();
      wait_led(n);
      chk("delay_from_seed", n, 16);

      // normal round: p1 at 5 ms, p0 at 7 ms, p2 at 9 ms
      d0 = done_cnt;
      goto(21); pulse_stop(3'b010);
      goto(29); pulse_stop(3'b001);
      goto(37); pulse_stop(3'b100);
      chk("rt1_done_tick", done_tick, 1);
      chk("rt1_state", state, 3);
      chk("rt1_p0", ptime(0), 7);
      chk("rt1_p1", ptime(1), 5);
      chk("rt1_p2", ptime(2), 9);
      chk("rt1_winner", winner, 1);
      chk("rt1_winner_valid", winner_valid, 1);
      tick(3);
      chk("rt1_done_once", done_cnt - d0, 1);
      chk("rt1_led_done", led, 0);

      // presses in DONE are ignored
      pulse_stop(3'b111);
      tick(2);
      chk("late_p0", ptime(0), 7);
      chk("late_p2", ptime(2), 9);
      chk("late_valid", player_valid, 3'b111);

      // clear beats start
      start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
      chk("clr_state", state, 0);
      chk("clr_time", player_time, 0);
      chk("clr_valid", player_valid, 0);
      chk("clr_wv", winner_valid, 0);

      // later start: delay 3..6 ms; repeat press keeps first time
      tick($urandom_range(0, 30));
      pulse_start();
      wait_led(n);
      chk("delay_range", (n >= 12 && n <= 24 && n % 4 == 0), 1);
      goto(9);  pulse_stop(3'b001);
      goto(13); pulse_stop(3'b001);
      goto(17); pulse_stop(3'b110);
      chk("rep_p0", ptime(0), 2);
      chk("rep_p1", ptime(1), 4);
      chk("rep_winner", winner, 0);
      pulse_clear();

      // false start
      l0 = led_cnt;
      pulse_start();
      tick(5);
      pulse_stop(3'b101);
      chk("fs_state", state, 4);
      chk("fs_bits", false_start, 3'b101);
      chk("fs_wv", winner_valid, 0);
      chk("fs_done_tick", done_tick, 1);
      tick(3);
      chk("fs_led_never", led_cnt - l0, 0);
      pulse_clear();

      // tie at 4 ms, player 0 times out
      pulse_start();
      wait_led(n);
      goto(17); pulse_stop(3'b110);
      wait_state(3, n);
      chk("to_cycles", cur + n, 80);
      chk("to_winner", winner, 1);
      chk("to_p0", ptime(0), 20);
      chk("to_p2", ptime(2), 4);
      chk("to_bits", timeout, 3'b001);
      pulse_clear();

      // async reset while ARMED
      pulse_start();
      wait_led(n);
      tick(6); pulse_stop(3'b001);
      tick(2);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_led", led, 0);
      chk("arst_state", state, 0);
      chk("arst_valid", player_valid, 0);
      chk("arst_time", player_time, 0);
      tick();
      reset_n = 1'b1;
      pulse_start();
      wait_led(n);
      chk("arst_delay_repeat", n, 16);
      pulse_clear();

      // random rounds
      for (int r = 0; r < 14; r++) begin
         tick($urandom_range(0, 40));
         pulse_start();
         for (int c = 0; c < 150 && state != 3'd3 && state != 3'd4; c++) begin
            if (led) stop = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            else     stop = ($urandom_range(0, 40) == 0) ? N'($urandom) : '0;
            clear = ($urandom_range(0, 250) == 0);
            tick();
         end
         stop = '0; clear = 1'b0;
         tick(3);
         stop = N'($urandom); start = $urandom_range(0, 1); clear = 1'b1;
         tick();
         stop = '0; start = 1'b0; clear = 1'b0;
      end

      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
